// File: rtl/oam_dma.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// oam_dma
//
// Sprite-attribute DMA engine. A CPU write to DMA_REG_ADDR latches a source
// page and stalls the CPU. The engine then copies 256 bytes from
// {page, 8'h00}..{page, 8'hFF} to the PPU OAM data port at OAM_DATA_ADDR,
// one READ/WRITE cycle pair per byte. While idle, the shared bus is a
// straight pass-through of the CPU bus.
//
// Optional feature (compile-time macro OAM_DMA_ALIGN_EN):
//   When defined, a free-running parity bit is kept. If HALT falls on a
//   parity-0 cycle, one ALIGN cycle is inserted so that every READ lands on
//   a parity-0 cycle. This gives 514 cycles per transfer instead of 513.
//   When undefined, HALT always goes straight to READ, and every transfer
//   takes 513 cycles.
//
// Parameters:
//   DMA_REG_ADDR  - CPU write address that triggers a transfer
//   OAM_DATA_ADDR - PPU OAM data port address targeted by DMA writes
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   cpu_addr   in   [15:0] CPU address
//   cpu_d_out  in   [7:0]  CPU write data
//   cpu_write  in   CPU write strobe
//   bus_d_in   in   [7:0]  read data returned from the memory bus
//   cpu_ready  out  CPU ready; 0 stalls the CPU
//   bus_addr   out  [15:0] shared bus address
//   bus_d_out  out  [7:0]  shared bus write data
//   bus_write  out  shared bus write strobe
//   dma_busy   out  high in every state except IDLE
//   dma_done   out  one-cycle pulse in the first IDLE cycle after the last write
// ---------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_ready,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  output logic        dma_busy,
  output logic        dma_done
);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t     state_reg,  state_next;
  logic [7:0] page_reg,   page_next;
  logic [7:0] index_reg,  index_next;
  logic [7:0] buffer_reg, buffer_next;
  logic       done_reg,   done_next;
`ifdef OAM_DMA_ALIGN_EN
  logic       parity_reg;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      page_reg   <= 8'h00;
      index_reg  <= 8'h00;
      buffer_reg <= 8'h00;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      page_reg   <= page_next;
      index_reg  <= index_next;
      buffer_reg <= buffer_next;
      done_reg   <= done_next;
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  // Free-running cycle parity. It is independent of the FSM, so the
  // alignment decision depends only on the cycle count since reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_reg <= 1'b0;
    else        parity_reg <= ~parity_reg;
  end
`endif

  // Next-state logic and outputs
  always_comb begin
    state_next  = state_reg;
    page_next   = page_reg;
    index_next  = index_reg;
    buffer_next = buffer_reg;
    done_next   = 1'b0;
    // Outside READ/WRITE the bus shows the CPU. Writes are only let
    // through in IDLE.
    bus_addr    = cpu_addr;
    bus_d_out   = cpu_d_out;
    bus_write   = 1'b0;
    cpu_ready   = 1'b0;
    dma_busy    = 1'b1;

    case (state_reg)
      IDLE: begin
        bus_write = cpu_write;
        cpu_ready = 1'b1;
        dma_busy  = 1'b0;
        // The trigger write itself still reaches the bus (bus_write above).
        if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
          page_next  = cpu_d_out;
          index_next = 8'h00;
          state_next = HALT;
        end
      end

      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // Parity toggles every cycle, so leaving HALT on parity 1 puts
        // READ on parity 0. Otherwise spend one ALIGN cycle first.
        state_next = parity_reg ? READ : ALIGN;
`else
        state_next = READ;
`endif
      end

`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        state_next = READ;
      end
`endif

      READ: begin
        bus_addr    = {page_reg, index_reg};
        buffer_next = bus_d_in;
        state_next  = WRITE;
      end

      WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_d_out  = buffer_reg;
        bus_write  = 1'b1;
        // The index wraps inside the page. The page register is never
        // incremented.
        index_next = index_reg + 8'h01;
        if (index_reg == 8'hFF) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = READ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dma_done = done_reg;

endmodule

// File: tb/tb_oam_dma.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_oam_dma
//
// Directed bench for oam_dma. A behavioural memory answers bus reads
// combinationally. Each transfer pushes its 256 expected {read address, data}
// pairs onto a scoreboard queue. Every OAM write seen on the bus pops one
// entry and compares it.
// ---------------------------------------------------------------------------
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  bus_d_in;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic        dma_busy;
  logic        dma_done;

  oam_dma dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_d_out (cpu_d_out),
    .cpu_write (cpu_write),
    .bus_d_in  (bus_d_in),
    .cpu_ready (cpu_ready),
    .bus_addr  (bus_addr),
    .bus_d_out (bus_d_out),
    .bus_write (bus_write),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done)
  );

  always #5 clk = ~clk;

  // Memory contents: either ~addr[7:0] or a page-dependent pattern.
  logic mem_inv;
  assign bus_d_in = mem_inv ? ~bus_addr[7:0] : (bus_addr[7:0] ^ bus_addr[15:8] ^ 8'h3C);

`ifdef OAM_DMA_ALIGN_EN
  // Cycle parity since reset release, used to pick the alignment case.
  logic m_par;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_par <= 1'b0;
    else        m_par <= ~m_par;
  end
`endif

  typedef struct packed {
    logic [15:0] raddr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_idle();
    cpu_addr  = 16'h1234;
    cpu_d_out = 8'h00;
    cpu_write = 1'b0;
  endtask

  // One complete DMA transfer from page pg.
  //   want_par : required parity in HALT (0/1), -1 = don't care
  //   inject   : rewrite the DMA register with 8'h05 during READ of index 8'h10
  //   rst_mid  : pull reset during WRITE of index 8'h80
  task automatic run_transfer(input logic [7:0] pg, input int want_par,
                              input bit inject, input bit rst_mid);
    int          busy_cnt;
    int          wr_cnt;
    int          exp_cycles;
    logic [15:0] prev_addr;
    logic [15:0] last_raddr;
    logic [7:0]  last_data;
    exp_t        e;

    @(negedge clk);
    exp_cycles = 513;
`ifdef OAM_DMA_ALIGN_EN
    // HALT parity is the inverse of the parity in the trigger cycle.
    if (want_par >= 0 && m_par == want_par[0]) @(negedge clk);
    if (m_par == 1'b1) exp_cycles = 514;
`endif

    // Trigger write: this cycle is still IDLE, so the write is passed through.
    cpu_addr  = 16'h4014;
    cpu_d_out = pg;
    cpu_write = 1'b1;
    #1;
    check("trig_pass_addr", 32'(bus_addr), 32'h4014);
    check("trig_pass_data", 32'(bus_d_out), 32'(pg));
    check("trig_pass_we",   32'(bus_write), 32'd1);
    check("trig_ready",     32'(cpu_ready), 32'd1);
    for (int i = 0; i < 256; i++) begin
      e.raddr = {pg, i[7:0]};
      e.data  = mem_inv ? ~i[7:0] : (i[7:0] ^ pg ^ 8'h3C);
      sb.push_back(e);
    end

    @(negedge clk);
    cpu_idle();
    #1;
    busy_cnt   = 0;
    wr_cnt     = 0;
    prev_addr  = 16'h0000;
    last_raddr = 16'h0000;
    last_data  = 8'h00;
    while (dma_busy && busy_cnt < 600) begin
      busy_cnt++;
      check("busy_ready", 32'(cpu_ready), 32'd0);
      if (busy_cnt == 1) begin
        check("halt_we",   32'(bus_write), 32'd0);
        check("halt_addr", 32'(bus_addr),  32'h1234);
      end
      if (busy_cnt == 2 && exp_cycles == 514) begin
        check("align_we",   32'(bus_write), 32'd0);
        check("align_addr", 32'(bus_addr),  32'h1234);
      end
      if (bus_write) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("read_addr", 32'(prev_addr), 32'(e.raddr));
          check("oam_addr",  32'(bus_addr),  32'h2004);
          check("oam_data",  32'(bus_d_out), 32'(e.data));
          last_raddr = prev_addr;
          last_data  = bus_d_out;
        end
        if (rst_mid && wr_cnt == 8'h80) begin
          // Asynchronous reset in the middle of WRITE of index 8'h80.
          cpu_addr  = 16'h5555;
          cpu_d_out = 8'h77;
          cpu_write = 1'b1;
          reset     = 1'b0;
          #1;
          check("rst_ready", 32'(cpu_ready), 32'd1);
          check("rst_busy",  32'(dma_busy),  32'd0);
          check("rst_done",  32'(dma_done),  32'd0);
          check("rst_we",    32'(bus_write), 32'd1);
          check("rst_addr",  32'(bus_addr),  32'h5555);
          check("rst_data",  32'(bus_d_out), 32'h77);
          cpu_write = 1'b0;
          #1;
          check("rst_we_low", 32'(bus_write), 32'd0);
          repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_hold_we",   32'(bus_write), 32'd0);
            check("rst_hold_busy", 32'(dma_busy),  32'd0);
          end
          @(negedge clk);
          reset = 1'b1;
          cpu_idle();
          repeat (4) begin
            @(negedge clk);
            #1;
            check("post_rst_busy", 32'(dma_busy),  32'd0);
            check("post_rst_we",   32'(bus_write), 32'd0);
          end
          $display("transfer page=%02h par_req=%0d reset after %0d writes, %0d left unwritten",
                   pg, want_par, wr_cnt + 1, sb.size());
          sb.delete();
          return;
        end
        wr_cnt++;
      end
      prev_addr = bus_addr;
      if (inject && !bus_write && bus_addr == {pg, 8'h10}) begin
        cpu_addr  = 16'h4014;
        cpu_d_out = 8'h05;
        cpu_write = 1'b1;
        #1;
        check("inject_no_we", 32'(bus_write), 32'd0);
      end else if (cpu_write) begin
        cpu_idle();
      end
      @(negedge clk);
      #1;
    end

    // This is the first IDLE cycle after the transfer.
    check("busy_cycles", 32'(busy_cnt), 32'(exp_cycles));
    check("write_count", 32'(wr_cnt), 32'd256);
    check("sb_empty",    32'(sb.size()), 32'd0);
    check("last_read",   32'(last_raddr), 32'({pg, 8'hFF}));
    check("last_data",   32'(last_data),  mem_inv ? 32'h00 : 32'(8'hFF ^ pg ^ 8'h3C));
    check("done_pulse",  32'(dma_done),  32'd1);
    check("idle_ready",  32'(cpu_ready), 32'd1);
    @(negedge clk);
    #1;
    check("done_clear",  32'(dma_done),  32'd0);
    check("idle_busy",   32'(dma_busy),  32'd0);
    $display("transfer page=%02h par_req=%0d busy_cycles=%0d writes=%0d",
             pg, want_par, busy_cnt, wr_cnt);
    sb.delete();
  endtask

  initial begin
    cpu_idle();
    reset   = 1'b0;
    mem_inv = 1'b0;

    // Reset state, with the bus following the CPU.
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", 32'(cpu_ready), 32'd1);
    check("reset_busy",  32'(dma_busy),  32'd0);
    check("reset_done",  32'(dma_done),  32'd0);
    check("reset_addr",  32'(bus_addr),  32'h1234);
    cpu_write = 1'b1;
    #1;
    check("reset_we_follow", 32'(bus_write), 32'd1);
    cpu_write = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("release_busy", 32'(dma_busy), 32'd0);
    end

    // A write to a neighbouring address is passed through and starts nothing.
    @(negedge clk);
    cpu_addr  = 16'h4013;
    cpu_d_out = 8'hAA;
    cpu_write = 1'b1;
    #1;
    check("pass_addr",  32'(bus_addr),  32'h4013);
    check("pass_data",  32'(bus_d_out), 32'hAA);
    check("pass_we",    32'(bus_write), 32'd1);
    check("pass_ready", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    cpu_idle();
    #1;
    check("pass_no_busy",  32'(dma_busy),  32'd0);
    check("pass_ready2",   32'(cpu_ready), 32'd1);
    $display("write 4013<=AA passed through, no transfer");

    run_transfer(8'h02, 1, 1'b0, 1'b0);
`ifdef OAM_DMA_ALIGN_EN
    run_transfer(8'h02, 0, 1'b0, 1'b0);
`endif
    run_transfer(8'h02, -1, 1'b1, 1'b0);
    run_transfer(8'h02, -1, 1'b0, 1'b1);
    mem_inv = 1'b1;
    run_transfer(8'hFF, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
